// File: rtl/piradip_capture_pkg.sv
// Shared types and sample helpers for the ADC trigger/capture block.
package piradip_capture_pkg;

    localparam int unsigned CAP_DATA_WIDTH   = 256;
    localparam int unsigned CAP_SAMPLE_WIDTH = 16;
    localparam int unsigned CAP_NLANES       = CAP_DATA_WIDTH / CAP_SAMPLE_WIDTH;
    localparam int unsigned CAP_LANE_W       = $clog2(CAP_NLANES);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DUMP} cap_state_t;

    typedef struct packed {
        logic                  hit;
        logic [CAP_LANE_W-1:0] lane;
    } crossing_t;

    function automatic logic signed [CAP_SAMPLE_WIDTH-1:0] lane(
        input logic [CAP_DATA_WIDTH-1:0] word,
        input int unsigned               i
    );
        return word[i*CAP_SAMPLE_WIDTH +: CAP_SAMPLE_WIDTH];
    endfunction

    // Lowest lane where the stream steps from <= thr to > thr; prev seeds lane 0.
    function automatic crossing_t first_crossing(
        input logic signed [CAP_SAMPLE_WIDTH-1:0] prev,
        input logic [CAP_DATA_WIDTH-1:0]          word,
        input logic signed [CAP_SAMPLE_WIDTH-1:0] thr
    );
        crossing_t                         r;
        logic signed [CAP_SAMPLE_WIDTH-1:0] p;
        logic signed [CAP_SAMPLE_WIDTH-1:0] c;
        r = '0;
        p = prev;
        for (int unsigned i = 0; i < CAP_NLANES; i++) begin
            c = lane(word, i);
            if (!r.hit && (p <= thr) && (c > thr)) begin
                r.hit  = 1'b1;
                r.lane = CAP_LANE_W'(i);
            end
            p = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/piradip_capture_ram.sv
// Simple dual-port capture buffer: one write port, registered one-cycle read port.
module piradip_capture_ram
    import piradip_capture_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned DATA_WIDTH = CAP_DATA_WIDTH,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/piradip_adc_trigger_capture.sv
// Armed threshold-trigger capture of the ADC stream with pre/post history, replayed on AXI4-Stream.
// Optional PIRADIP_CAPTURE_TIMESTAMP_EN adds a valid-word timestamp of the trigger word.
module piradip_adc_trigger_capture
    import piradip_capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = CAP_DATA_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = CAP_SAMPLE_WIDTH,
    parameter int unsigned DEPTH        = 1024,
    localparam int unsigned NLANES      = DATA_WIDTH / SAMPLE_WIDTH,
    localparam int unsigned LANE_W      = $clog2(NLANES),
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] threshold,
    input  logic [AW:0]             pre_words,
    input  logic [AW:0]             post_words,
    output logic                    busy,
    output logic [LANE_W-1:0]       trig_lane,
    output logic                    cfg_err
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
    ,
    output logic [63:0]             trig_timestamp
`endif
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = AW + 2;

    cap_state_t                     state;
    logic [AW-1:0]                  wr_ptr;
    logic [AW-1:0]                  rd_ptr;
    logic [AW-1:0]                  start_ptr;
    logic [CW-1:0]                  cnt;
    logic [CW-1:0]                  rd_left;
    logic [CW-1:0]                  pre_q;
    logic [CW-1:0]                  post_q;
    logic signed [SAMPLE_WIDTH-1:0] thr_q;
    logic signed [SAMPLE_WIDTH-1:0] prev_q;

    logic                  rd_pend;
    logic                  rd_last_pend;
    logic                  sk_valid;
    logic                  sk_last;
    logic [DATA_WIDTH-1:0] sk_data;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic            capturing;
    logic            ram_we;
    crossing_t       xing;
    logic            trig_fire;
    logic [AW-1:0]   trig_start;
    logic            pop;
    logic [2:0]      fill_lvl;
    logic            rd_issue;
    logic [TW-1:0]   cfg_total;
    logic            cfg_bad;

    assign s_axis_tready = 1'b1;

    assign capturing  = (state == FILL) || (state == ARMED) || (state == POST);
    assign ram_we     = capturing && s_axis_tvalid;
    assign xing       = first_crossing(prev_q, s_axis_tdata, thr_q);
    assign trig_fire  = (state == ARMED) && s_axis_tvalid && !abort && xing.hit;
    assign trig_start = wr_ptr - AW'(pre_q);
    assign pop        = m_axis_tvalid && m_axis_tready;
    // Words held or in flight after this cycle's pop; read only while the 2-entry skid has room.
    assign fill_lvl   = 3'(m_axis_tvalid) + 3'(sk_valid) + 3'(rd_pend) - 3'(pop);
    assign rd_issue   = (state == DUMP) && (rd_left != '0) && (fill_lvl < 3'd2);
    assign cfg_total  = TW'(pre_words) + TW'(post_words);
    assign cfg_bad    = (post_words == '0) || (cfg_total > TW'(DEPTH));

    piradip_capture_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .re    (rd_issue),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Capture FSM, write/read pointers and trigger bookkeeping.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            start_ptr <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            thr_q     <= '0;
            prev_q    <= '0;
            busy      <= 1'b0;
            trig_lane <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_left <= rd_left - CW'(1);
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_err <= 1'b0;
                            pre_q   <= pre_words;
                            post_q  <= post_words;
                            thr_q   <= threshold;
                            prev_q  <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= (pre_words == '0) ? ARMED : FILL;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (s_axis_tvalid) begin
                        prev_q <= lane(s_axis_tdata, NLANES - 1);
                        if (cnt + CW'(1) == pre_q) begin
                            cnt   <= '0;
                            state <= ARMED;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (s_axis_tvalid) begin
                        prev_q <= lane(s_axis_tdata, NLANES - 1);
                        if (xing.hit) begin
                            start_ptr <= trig_start;
                            trig_lane <= xing.lane;
                            cnt       <= CW'(1);
                            if (post_q == CW'(1)) begin
                                rd_ptr  <= trig_start;
                                rd_left <= pre_q + post_q;
                                state   <= DUMP;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (s_axis_tvalid) begin
                        if (cnt + CW'(1) == post_q) begin
                            rd_ptr  <= start_ptr;
                            rd_left <= pre_q + post_q;
                            state   <= DUMP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DUMP: begin
                    if (pop && m_axis_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register plus one spare entry absorbing the read that was in flight when tready dropped.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            sk_valid      <= 1'b0;
            sk_last       <= 1'b0;
            sk_data       <= '0;
            rd_pend       <= 1'b0;
            rd_last_pend  <= 1'b0;
        end else begin
            rd_pend      <= rd_issue;
            rd_last_pend <= rd_issue && (rd_left == CW'(1));
            if (!m_axis_tvalid || pop) begin
                if (sk_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= sk_data;
                    m_axis_tlast  <= sk_last;
                    sk_valid      <= rd_pend;
                    sk_data       <= ram_rdata;
                    sk_last       <= rd_last_pend;
                end else begin
                    m_axis_tvalid <= rd_pend;
                    m_axis_tlast  <= rd_pend && rd_last_pend;
                    if (rd_pend) begin
                        m_axis_tdata <= ram_rdata;
                    end
                end
            end else if (rd_pend) begin
                sk_valid <= 1'b1;
                sk_data  <= ram_rdata;
                sk_last  <= rd_last_pend;
            end
        end
    end

`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
    logic [63:0] ts_cnt;

    // Free-running count of valid input words; the trigger word's count is latched.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ts_cnt         <= '0;
            trig_timestamp <= '0;
        end else begin
            if (s_axis_tvalid) begin
                ts_cnt <= ts_cnt + 64'd1;
            end
            if (trig_fire) begin
                trig_timestamp <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_piradip_adc_trigger_capture.sv
// Scoreboard bench for piradip_adc_trigger_capture (DEPTH=16); PIRADIP_CAPTURE_TIMESTAMP_EN also checks the timestamp.
module tb_piradip_adc_trigger_capture;
    import piradip_capture_pkg::*;

    localparam int unsigned DW    = 256;
    localparam int unsigned SW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          arm;
    logic          abort;
    logic [SW-1:0] threshold;
    logic [AW:0]   pre_words;
    logic [AW:0]   post_words;
    logic          busy;
    logic [3:0]    trig_lane;
    logic          cfg_err;
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
    logic [63:0]   trig_timestamp;
`endif

    piradip_adc_trigger_capture #(
        .DATA_WIDTH   (DW),
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .arm            (arm),
        .abort          (abort),
        .threshold      (threshold),
        .pre_words      (pre_words),
        .post_words     (post_words),
        .busy           (busy),
        .trig_lane      (trig_lane),
        .cfg_err        (cfg_err)
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
        ,
        .trig_timestamp (trig_timestamp)
`endif
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            vcount   = 0;
    int            ready_mode = 1;
    exp_t          exp_q[$];
    logic [DW-1:0] words [64];

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // tready: 0 = low, 1 = high, 2 = random 50%
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #2;
            if (ready_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
            else                 m_axis_tready = (ready_mode == 1);
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold-stability on stalls.
    initial begin
        logic          stall_q;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        exp_t          e;
        stall_q = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (stall_q) begin
                n_checks++;
                if (!(m_axis_tvalid && m_axis_tdata == stall_data && m_axis_tlast == stall_last)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got tvalid=%0b tlast=%0b tdata=%h required tvalid=1 tlast=%0b tdata=%h",
                             m_axis_tvalid, m_axis_tlast, m_axis_tdata, stall_last, stall_data);
                end
            end
            stall_q    = m_axis_tvalid && !m_axis_tready && !areset;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready && !areset) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got tdata=%h tlast=%0b required no transfer", m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                        n_fail++;
                        $display("FAIL frame_word: got tdata=%h tlast=%0b required tdata=%h tlast=%0b",
                                 m_axis_tdata, m_axis_tlast, e.data, e.last);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic void set_lane(input int w, input int l, input int val);
        words[w][l*SW +: SW] = SW'(val);
    endfunction

    function automatic void build_ramp(input int n, input int off);
        for (int w = 0; w < n; w++)
            for (int l = 0; l < 16; l++)
                set_lane(w, l, w*16 + l + off);
    endfunction

    task automatic arm_cfg(input int pre, input int post, input int thr);
        pre_words  = (AW+1)'(pre);
        post_words = (AW+1)'(post);
        threshold  = SW'(thr);
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = words[i];
            vcount++;
            step();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic expect_frame(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.data = words[i];
            e.last = (i == hi);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        @(negedge aclk);
        while (busy === 1'b1 && c < 500) begin
            @(negedge aclk);
            c++;
        end
        check({name, "_done"}, 64'(busy), 64'd0);
        check({name, "_all_words"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_frame(input string name, input int pre, input int post, input int thr,
                             input int trig, input int exp_lane, input bit chk_first, input bit abort_dump);
        int ts_base;
        arm_cfg(pre, post, thr);
        check({name, "_busy"}, 64'(busy), 64'd1);
        check({name, "_cfg_err"}, 64'(cfg_err), 64'd0);
        ts_base = vcount;
        expect_frame(trig - pre, trig + post - 1);
        stream(trig + post);
        if (chk_first) begin
            step();
            step();
            check({name, "_first_tvalid"}, 64'(m_axis_tvalid), 64'd1);
        end
        if (abort_dump) begin
            step();
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        wait_idle(name);
        check({name, "_trig_lane"}, 64'(trig_lane), 64'(exp_lane));
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
        check({name, "_timestamp"}, trig_timestamp, 64'(ts_base + trig));
`endif
        step();
    endtask

    initial begin
        int c;
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        arm = 1'b0;
        abort = 1'b0;
        threshold = '0;
        pre_words = '0;
        post_words = '0;
        repeat (3) step();
        areset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(|m_axis_tdata), 64'd0);
        check("rst_trig_lane", 64'(trig_lane), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
        check("rst_timestamp", trig_timestamp, 64'd0);
`endif

        // Ramp: sample n = n - 544, first > 100 at word 40 lane 5
        build_ramp(44, -544);
        run_frame("ramp", 4, 4, 100, 40, 5, 1'b1, 1'b0);

        // Boundary: word1 lane15 = 100 (equality only), word2 lane0 = 101
        for (int l = 0; l < 16; l++) begin
            set_lane(0, l, -(l + 1));
            set_lane(1, l, 50 + l);
            set_lane(2, l, 101 + l);
            set_lane(3, l, 200 + l);
        end
        set_lane(1, 15, 100);
        run_frame("boundary", 1, 2, 100, 2, 0, 1'b1, 1'b0);

        // Wrap: full-ring frame, trigger on word 37 lane 3
        build_ramp(43, 0);
        set_lane(37, 3, 2000);
        run_frame("wrap", 10, 6, 1000, 37, 3, 1'b1, 1'b0);

        // Backpressure with abort pulsed during DUMP
        for (int w = 0; w < 11; w++)
            for (int l = 0; l < 16; l++)
                set_lane(w, l, -(w*16 + l) - 1);
        set_lane(6, 9, 7);
        ready_mode = 2;
        run_frame("bp", 3, 5, 0, 6, 9, 1'b0, 1'b1);
        ready_mode = 1;

        // Config errors
        arm_cfg(12, 5, 0);
        check("cfg_sum_err", 64'(cfg_err), 64'd1);
        check("cfg_sum_busy", 64'(busy), 64'd0);
        arm_cfg(3, 0, 0);
        check("cfg_post0_err", 64'(cfg_err), 64'd1);
        check("cfg_post0_busy", 64'(busy), 64'd0);

        // Abort in ARMED, simultaneous with a crossing word
        arm_cfg(0, 4, 30000);
        check("abort_cfg_err_clr", 64'(cfg_err), 64'd0);
        check("abort_busy_armed", 64'(busy), 64'd1);
        for (int w = 0; w < 3; w++)
            for (int l = 0; l < 16; l++)
                set_lane(w, l, 500);
        stream(3);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16{16'd31000}};
        vcount++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        s_axis_tvalid = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (10) step();
        check("abort_no_tvalid", 64'(m_axis_tvalid), 64'd0);

        // pre=0, post=1: prev cleared at arm so lane 0 of the first word fires
        for (int l = 0; l < 16; l++) set_lane(0, l, 101 + l);
        run_frame("single", 0, 1, 100, 0, 0, 1'b1, 1'b0);

        // Reset during DUMP after three words
        build_ramp(44, -544);
        ready_mode = 0;
        arm_cfg(4, 4, 100);
        expect_frame(36, 43);
        stream(44);
        c = 0;
        @(negedge aclk);
        while (!m_axis_tvalid && c < 20) begin
            @(negedge aclk);
            c++;
        end
        check("rst_dump_tvalid_up", 64'(m_axis_tvalid), 64'd1);
        step();
        ready_mode = 1;
        repeat (3) step();
        ready_mode = 0;
        areset = 1'b1;
        step();
        areset = 1'b0;
        vcount = 0;
        check("rst_dump_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_dump_busy", 64'(busy), 64'd0);
        check("rst_dump_popped", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        ready_mode = 1;
        repeat (5) step();
        check("rst_dump_quiet", 64'(m_axis_tvalid), 64'd0);
        for (int l = 0; l < 16; l++) begin
            set_lane(0, l, -(l + 1));
            set_lane(1, l, 50 + l);
            set_lane(2, l, 101 + l);
            set_lane(3, l, 200 + l);
        end
        set_lane(1, 15, 100);
        run_frame("post_rst", 1, 2, 100, 2, 0, 1'b1, 1'b0);

        repeat (5) step();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
